multicycle_control: RTL

//  Multi-cycle RISC-V control FSM. Successor to the single-cycle opcode decoder.

---
 rtl/ctrl_pkg.sv | 52 +++++
 rtl/mem_wait_timer.sv | 42 ++++
 rtl/multicycle_control.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pkg.sv
// Shared encodings for the multi-cycle RISC-V control FSM: opcodes, states,
// ALU operand/operation selects and trap causes.
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [3:0] {
        S_START    = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXEC_R   = 4'd3,
        S_EXEC_I   = 4'd4,
        S_WB_ALU   = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_MEM_WR   = 4'd9,
        S_BRANCH   = 4'd10,
        S_TRAP     = 4'd11
    } state_e;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_FUNCT = 2'b10
    } alu_op_e;

    localparam logic SRC_A_PC  = 1'b0;
    localparam logic SRC_A_RS1 = 1'b1;

    typedef enum logic [1:0] {
        SRC_B_RS2  = 2'b00,
        SRC_B_FOUR = 2'b01,
        SRC_B_IMM  = 2'b10
    } src_b_e;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_ILLEGAL = 2'b01,
        CAUSE_TIMEOUT = 2'b10
    } cause_e;

    // States that hold a memory request open until mem_ready.
    function automatic logic is_wait_state(state_e s);
        return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on mem_ready and flags the cycle on which the
// WAIT_MAX-th consecutive non-ready cycle occurs. WAIT_MAX=0 never expires.
module mem_wait_timer #(
    parameter int WAIT_MAX = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic waiting,
    input  logic ready,
    output logic expired
);

    localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX);
    localparam logic [CW-1:0] LIMIT = (WAIT_MAX == 0) ? '0 : CW'(WAIT_MAX - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // The count holds the number of earlier stalled cycles, so reaching LIMIT
    // while still not ready marks the last cycle allowed to wait.
    assign expired = (WAIT_MAX != 0) && waiting && !ready && (cnt_q == LIMIT);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (waiting && !ready && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: state flops use non-blocking assignments so all registers update together at the edge.
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle RISC-V control FSM: sequences fetch/decode/execute/memory/writeback,
// handles memory wait states with a timeout, traps, and counts retired instructions.
module multicycle_control
    import ctrl_pkg::*;
#(
    parameter int OPCODE_W = 7,
    parameter int WAIT_MAX = 16,
    parameter int CNT_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    input  logic                trap_clear,
    output logic                mem_req,
    output logic                mem_we,
    output logic                i_or_d,
    output logic                ir_write,
    output logic                pc_write,
    output logic                branch,
    output logic                reg_write,
    output logic                mem_to_reg,
    output logic                alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [1:0]          alu_op,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic [CNT_W-1:0]    instret,
    output logic [3:0]          state_o
);

    state_e              state_q, state_d;
    logic [OPCODE_W-1:0] opcode_q, opcode_d;
    cause_e              cause_q, cause_d;
    logic [CNT_W-1:0]    instret_q, instret_d;
    logic                retire;
    logic                waiting;
    logic                timer_clear;
    logic                expired;

    assign waiting     = is_wait_state(state_q);
    assign timer_clear = is_wait_state(state_d) && (state_d != state_q);

    mem_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (timer_clear),
        .waiting (waiting),
        .ready   (mem_ready),
        .expired (expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_START;
            opcode_q  <= '0;
            cause_q   <= CAUSE_NONE;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            opcode_q  <= opcode_d;
            cause_q   <= cause_d;
            instret_q <= instret_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        cause_d  = cause_q;
        retire   = 1'b0;
        unique case (state_q)
            S_START: state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    state_d = S_DECODE;
                end else if (expired) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_DECODE: begin
                opcode_d = opcode;
                case (opcode)
                    OPCODE_W'(OP_R):      state_d = S_EXEC_R;
                    OPCODE_W'(OP_I):      state_d = S_EXEC_I;
                    OPCODE_W'(OP_LOAD),
                    OPCODE_W'(OP_STORE):  state_d = S_MEM_ADDR;
                    OPCODE_W'(OP_BRANCH): state_d = S_BRANCH;
                    default: begin
                        state_d = S_TRAP;
                        cause_d = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_d = S_WB_ALU;
            S_MEM_ADDR: state_d = (opcode_q == OPCODE_W'(OP_LOAD)) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: begin
                if (mem_ready) begin
                    state_d = S_WB_MEM;
                end else if (expired) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_MEM_WR: begin
                if (mem_ready) begin
                    state_d = S_FETCH;
                    retire  = 1'b1;
                end else if (expired) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end
            end
            S_WB_ALU, S_WB_MEM, S_BRANCH: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_TRAP: begin
                if (trap_clear) begin
                    state_d = S_FETCH;
                    cause_d = CAUSE_NONE;
                end
            end
            default: state_d = S_START;
        endcase
    end

    // Counter wraps naturally at 2^CNT_W.
    assign instret_d = retire ? instret_q + 1'b1 : instret_q;

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        i_or_d     = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = SRC_A_PC;
        alu_src_b  = SRC_B_RS2;
        alu_op     = ALU_ADD;
        trap       = 1'b0;
        unique case (state_q)
            S_FETCH: begin
                // IR load and PC+4 commit in the same cycle the fetch completes.
                mem_req   = 1'b1;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                alu_src_b = SRC_B_FOUR;
            end
            S_EXEC_R: begin
                alu_src_a = SRC_A_RS1;
                alu_op    = ALU_FUNCT;
            end
            S_EXEC_I: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
                alu_op    = ALU_FUNCT;
            end
            S_WB_ALU: reg_write = 1'b1;
            S_MEM_ADDR: begin
                alu_src_a = SRC_A_RS1;
                alu_src_b = SRC_B_IMM;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                i_or_d  = 1'b1;
            end
            S_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                i_or_d  = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = SRC_A_RS1;
                alu_op    = ALU_SUB;
                branch    = 1'b1;
            end
            S_TRAP: trap = 1'b1;
            default: ;
        endcase
    end

    assign trap_cause = cause_q;
    assign instret    = instret_q;
    assign state_o    = state_q;

endmodule
